// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register index, per-stage control pair and hazard sequencer states.
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef struct packed {
        logic advance;
        logic flush;
    } stage_ctrl_t;

    typedef enum logic {
        HC_RUN  = 1'b0,
        HC_HOLD = 1'b1
    } hc_state_e;

    // A source operand only matters when the instruction actually reads it.
    function automatic logic reg_hit(input lc3b_reg src, input lc3b_reg dest, input logic used);
        return used & (src == dest);
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register an EX-stage load is writing.
module pipe_hazard_detect
    import lc3b_types::*;
(
    input  lc3b_reg id_sr1,
    input  lc3b_reg id_sr2,
    input  logic    id_use_sr1,
    input  logic    id_use_sr2,
    input  lc3b_reg ex_dest,
    input  logic    ex_is_load,
    output logic    load_use
);

    assign load_use = ex_is_load &
                      (reg_hit(id_sr1, ex_dest, id_use_sr1) |
                       reg_hit(id_sr2, ex_dest, id_use_sr2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage LC-3b pipeline sequencer: memory wait, load-use bubble and taken-transfer flush.
// Optional saturating event counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import lc3b_types::*;
#(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_resp,
    input  logic              dmem_req,
    input  logic              dmem_resp,
    input  logic [2:0]        id_sr1,
    input  logic [2:0]        id_sr2,
    input  logic              id_use_sr1,
    input  logic              id_use_sr2,
    input  logic [2:0]        ex_dest,
    input  logic              ex_is_load,
    input  logic              mem_br_taken,
    output logic              imem_read,
    output logic              dmem_op_en,
    output logic              pc_load,
    output logic              ifid_advance,
    output logic              idex_advance,
    output logic              exmem_advance,
    output logic              memwb_advance,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              stall_o,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_bubble,
    output logic [PERF_W-1:0] perf_flush
);

    hc_state_e   state, state_next;
    logic        i_done, d_done, i_done_next, d_done_next;
    logic        i_pend, d_pend, i_ok, d_ok, mem_ok;
    logic        load_use;
    logic        memwb_adv;
    stage_ctrl_t ifid_c, idex_c, exmem_c;

    pipe_hazard_detect u_hazard_detect (
        .id_sr1     (id_sr1),
        .id_sr2     (id_sr2),
        .id_use_sr1 (id_use_sr1),
        .id_use_sr2 (id_use_sr2),
        .ex_dest    (ex_dest),
        .ex_is_load (ex_is_load),
        .load_use   (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HC_RUN;
            i_done <= 1'b0;
            d_done <= 1'b0;
        end else begin
            state  <= state_next;
            i_done <= i_done_next;
            d_done <= d_done_next;
        end
    end

    // Done flags are only meaningful while a split response is being held.
    assign i_pend = (state == HC_HOLD) & i_done;
    assign d_pend = (state == HC_HOLD) & d_done;
    assign i_ok   = imem_resp | i_pend;
    assign d_ok   = !dmem_req | dmem_resp | d_pend;
    assign mem_ok = i_ok & d_ok;

    always_comb begin
        state_next  = state;
        i_done_next = i_done;
        d_done_next = d_done;
        imem_read   = 1'b0;
        dmem_op_en  = 1'b0;
        pc_load     = 1'b0;
        stall_o     = 1'b0;
        memwb_adv   = 1'b0;
        ifid_c      = '0;
        idex_c      = '0;
        exmem_c     = '0;

        if (rst_n) begin
            imem_read  = !i_pend;
            dmem_op_en = dmem_req & !d_pend;

            if (!mem_ok) begin
                stall_o     = 1'b1;
                i_done_next = i_pend | imem_resp;
                d_done_next = d_pend | dmem_resp;
            end else if (mem_br_taken) begin
                pc_load     = 1'b1;
                ifid_c      = '{advance: 1'b1, flush: 1'b1};
                idex_c      = '{advance: 1'b1, flush: 1'b1};
                exmem_c     = '{advance: 1'b1, flush: 1'b1};
                memwb_adv   = 1'b1;
                i_done_next = 1'b0;
                d_done_next = 1'b0;
            end else if (load_use) begin
                // IF holds its fetched instruction, so it must not be fetched again.
                idex_c      = '{advance: 1'b1, flush: 1'b1};
                exmem_c     = '{advance: 1'b1, flush: 1'b0};
                memwb_adv   = 1'b1;
                i_done_next = 1'b1;
                d_done_next = 1'b0;
            end else begin
                pc_load     = 1'b1;
                ifid_c      = '{advance: 1'b1, flush: 1'b0};
                idex_c      = '{advance: 1'b1, flush: 1'b0};
                exmem_c     = '{advance: 1'b1, flush: 1'b0};
                memwb_adv   = 1'b1;
                i_done_next = 1'b0;
                d_done_next = 1'b0;
            end

            state_next = (i_done_next | d_done_next) ? HC_HOLD : HC_RUN;
        end
    end

    assign ifid_advance  = ifid_c.advance;
    assign ifid_flush    = ifid_c.flush;
    assign idex_advance  = idex_c.advance;
    assign idex_flush    = idex_c.flush;
    assign exmem_advance = exmem_c.advance;
    assign exmem_flush   = exmem_c.flush;
    assign memwb_advance = memwb_adv;

`ifdef PIPE_PERF_CNT_EN
    logic ev_bubble, ev_flush;

    // A bubble is the only case that flushes ID/EX without loading the PC.
    assign ev_bubble = idex_flush & !pc_load;
    assign ev_flush  = ifid_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall  <= '0;
            perf_bubble <= '0;
            perf_flush  <= '0;
        end else begin
            if (stall_o && (perf_stall != '1))
                perf_stall <= perf_stall + PERF_W'(1);
            if (ev_bubble && (perf_bubble != '1))
                perf_bubble <= perf_bubble + PERF_W'(1);
            if (ev_flush && (perf_flush != '1))
                perf_flush <= perf_flush + PERF_W'(1);
        end
    end
`else
    assign perf_stall  = '0;
    assign perf_bubble = '0;
    assign perf_flush  = '0;
`endif

endmodule
